pcs_rx_block_lock: RTL

- Receive-side controller for the 10G PCS.
- Implements the Clause 49 block-synchronisation state machine over the 2-bit sync headers delivered by the GTY RX gearbox.
- Issues single-cycle gearbox slip requests until 64b/66b block alignment is found, then monitors header error density to detect loss of lock.
- Sits between the GTY RX gearbox outputs and the RX descrambler/decoder; `o_block_lock` gates the downstream decoder.

---
 rtl/pcs_rx_block_lock.sv | 106 ++++++++++
 1 files changed

// File: rtl/pcs_rx_block_lock.sv
// 64b/66b block-lock controller: hunts for sync-header alignment with gearbox slips,
// then tracks invalid-header density per window to detect loss of lock.
module pcs_rx_block_lock #(
    parameter int unsigned SH_CNT_MAX   = 64,
    parameter int unsigned SH_INVLD_MAX = 16,
    parameter int unsigned SLIP_WAIT    = 32
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx_hdr_valid,
    input  logic [1:0] i_rx_hdr,
    output logic       o_rx_slip,
    output logic       o_block_lock,
    output logic [7:0] o_slip_cnt
);

    localparam int unsigned SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_TEST_SH   = 2'd0,
        ST_SLIP      = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_t;

    state_t              state;
    logic [SH_W-1:0]     sh_cnt;
    logic [SH_W-1:0]     sh_invld_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic hdr_ok_c;
    logic win_end_c;
    logic invld_hit_c;
    logic sample_c;
    logic slip_now_c;

    // Header classification and the single condition that launches a slip.
    always_comb begin
        hdr_ok_c    = i_rx_hdr[1] ^ i_rx_hdr[0];
        win_end_c   = (sh_cnt == SH_W'(SH_CNT_MAX - 1));
        invld_hit_c = (sh_invld_cnt == SH_W'(SH_INVLD_MAX - 1));
        sample_c    = (state == ST_TEST_SH) && i_rx_hdr_valid;
        slip_now_c  = sample_c && !hdr_ok_c && (!o_block_lock || invld_hit_c);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_TEST_SH;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            wait_cnt     <= '0;
            o_rx_slip    <= 1'b0;
            o_block_lock <= 1'b0;
            o_slip_cnt   <= 8'd0;
        end else begin
            // Pulse is asserted on entry to SLIP so it is high exactly while in SLIP.
            o_rx_slip <= slip_now_c;
            if (slip_now_c && (o_slip_cnt != 8'hFF)) begin
                o_slip_cnt <= o_slip_cnt + 8'd1;
            end

            case (state)
                ST_TEST_SH: begin
                    if (slip_now_c) begin
                        state        <= ST_SLIP;
                        o_block_lock <= 1'b0;
                        sh_cnt       <= '0;
                        sh_invld_cnt <= '0;
                    end else if (i_rx_hdr_valid) begin
                        if (win_end_c) begin
                            o_block_lock <= 1'b1;
                            sh_cnt       <= '0;
                            sh_invld_cnt <= '0;
                        end else begin
                            sh_cnt <= SH_W'(sh_cnt + 1'b1);
                            if (!hdr_ok_c) begin
                                sh_invld_cnt <= SH_W'(sh_invld_cnt + 1'b1);
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    state        <= ST_SLIP_WAIT;
                    sh_cnt       <= '0;
                    sh_invld_cnt <= '0;
                    wait_cnt     <= '0;
                end
                ST_SLIP_WAIT: begin
                    // Gearbox realigns; headers are meaningless until the wait expires.
                    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                        state        <= ST_TEST_SH;
                        wait_cnt     <= '0;
                        sh_cnt       <= '0;
                        sh_invld_cnt <= '0;
                    end else begin
                        wait_cnt <= WAIT_W'(wait_cnt + 1'b1);
                    end
                end
                default: begin
                    state <= ST_TEST_SH;
                end
            endcase
        end
    end

endmodule
